io_key_switch_device: RTL and testbench
=======================================

// Module: io_key_switch_device
// PURPOSE
//  Memory-mapped input peripheral for KEY pushbuttons and SW slide switches, downstream of the memory unit.
//  - Synchronises and debounces both inputs.
//  - Latches change events in sticky ready/overrun status bits.
//  - Raises a level interrupt when an enabled ready bit is set.
//  Serves the memory unit's load/store port at ADDR_KEY/ADDR_SW, plus one control register for each.
// PARAMETERS
//  DBITS            32            bus data/address width
//  KEY_WIDTH        4             number of pushbuttons (pins active-low)
//  SW_WIDTH         10            number of switches (active-high)
//  DEBOUNCE_CYCLES  10000         clk cycles a synchronised input must hold before acceptance (>=1)
//  ADDR_KDATA       32'hF0000010  KEY data reg, read-only
//  ADDR_SDATA       32'hF0000014  SW data reg, read-only
//  ADDR_KCTRL       32'hF0000110  KEY control/status reg
//  ADDR_SCTRL       32'hF0000114  SW control/status reg
// PORTS
//  clk     in   1           processor clock
//  reset   in   1           asynchronous, active-high reset
//  addr    in   DBITS       memory-unit byte address (full compare, no aliasing)
//  wrData  in   DBITS       store data
//  we      in   1           store strobe, one cycle per store
//  re      in   1           load strobe, one cycle per load
//  KEY     in   KEY_WIDTH   raw board pushbuttons, active-low
//  SW      in   SW_WIDTH    raw board switches
//  rdData  out  DBITS       load data, combinational from addr; 0 when hit=0
//  hit     out  1           addr matches one of the four registers
//  intr    out  1           (kRdy&kIE)|(sRdy&sIE), registered-state only
// BEHAVIOUR
//  Reset values:
//  - all sync/debounce flops, KDATA, SDATA, status, IE and intr = 0
//  - KEY sync flops reset to released (~KEY=0)
//  Input path, per bit-vector:
//  - 2-flop synchroniser, then debouncer (candidate, counter, stable)
//  - If sync != candidate: candidate <= sync, cnt <= 0.
//  - Else if cnt == DEBOUNCE_CYCLES-1 and stable != candidate: stable <= candidate, change pulse.
//  - Otherwise cnt saturates.
//  - Stable updates on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the new level.
//  - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
//  - KDATA = stable(~KEY); SDATA = stable(SW). Both zero-extended to DBITS.
//  CTRL layout:
//  - bit0 RDY: read-only, set by change pulse.
//  - bit2 OVR: set if a change pulse arrives while RDY=1 and no clearing read on that edge.
//  - bit8 IE: read/write.
//  - Store writes IE from wrData[8]; a store with wrData[2]=0 clears OVR; writing wrData[2]=1 has no effect; RDY write ignored.
//  - Other bits read 0.
//  Side effects:
//  - Load (re) of KDATA/SDATA clears the matching RDY at the edge.
//  - Simultaneous change pulse + clearing read: RDY stays 1, OVR unchanged (new event wins).
//  - Stores to KDATA/SDATA are ignored.
//  - Loads of CTRL have no side effects.
//  - re and we together on one address: both take effect.
//  Reads are zero-latency combinational (the memory unit samples in the same cycle); all state changes occur on posedge clk.
//  Unmapped addr: hit=0, rdData=0, no state change.
//  Reset asserted mid-debounce or with pending RDY: everything returns to reset values immediately; no pulse is generated on release for inputs still at the reset level.
// STRUCTURE
//  Shared package io_pkg:
//  - address constants
//  - CTRL bit indices: RDY=0, OVR=2, IE=8
//  - localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1)
//  Sub-module io_debouncer #(WIDTH, DEBOUNCE_CYCLES, RESET_VAL):
//  - synchroniser + debouncer, outputs stable[WIDTH] and change pulse
//  - instantiated twice (KEY inverted before entry)
//  Top level holds address decode, status registers, read mux and intr.
// TESTING (DEBOUNCE_CYCLES=4 for bench)
//  1 Reset: reset=1 mid-run -> rdData at KDATA/SDATA/KCTRL/SCTRL all 0, intr=0, hit=1.
//  2 Debounce latency: KEY 1111->1110 held -> KDATA=1 and KCTRL=0x001 exactly at the 7th edge. A 3-cycle SW[5] pulse -> SDATA stays 0, SCTRL.RDY stays 0.
//  3 Read-clear/overrun: KEY press, then release without a read -> KCTRL=0x005. Store 0 to KCTRL -> 0x001. Load KDATA -> KCTRL=0x000.
//  4 Collision: load KDATA on the same edge as a change pulse -> KCTRL RDY=1, OVR=0.
//  5 Interrupt: store 0x100 to SCTRL, flip SW[0] -> intr rises on the SDATA update edge. Load SDATA -> intr falls the next edge.
//  6 Decode: load 0xF0000018, store 0xFFFFFFFF to KDATA -> hit=0 / state unchanged, rdData=0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the KEY/SW memory-mapped input peripheral:
// register addresses, control/status bit positions and counter sizing.
package io_pkg;

    localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
    localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

    localparam int RDY_BIT = 0;
    localparam int OVR_BIT = 2;
    localparam int IE_BIT  = 8;

    localparam int DEFAULT_DEBOUNCE = 10000;

    // Counter must be able to hold DEBOUNCE_CYCLES-1 for any legal setting.
    function automatic int cntWidth(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int CNT_W = cntWidth(DEFAULT_DEBOUNCE);

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchroniser followed by a candidate/counter/stable debouncer.
// The change output is a single-cycle strobe on the edge where stable updates.
module io_debouncer
    import io_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic             change
);

    localparam int               DB_CNT_W = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]    syncP0;
    logic [WIDTH-1:0]    syncP1;
    logic [WIDTH-1:0]    cand;
    logic [DB_CNT_W-1:0] cnt;

    // Decoded from registered state so the status logic can react on the same edge.
    assign change = (syncP1 == cand) && (cnt == CNT_LAST) && (stable != cand);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncP0 <= {WIDTH{RESET_VAL}};
            syncP1 <= {WIDTH{RESET_VAL}};
            cand   <= {WIDTH{RESET_VAL}};
            stable <= {WIDTH{RESET_VAL}};
            cnt    <= '0;
        end else begin
            syncP0 <= din;
            syncP1 <= syncP0;
            if (syncP1 != cand) begin
                cand <= syncP1;
                cnt  <= '0;
            end else if (change) begin
                stable <= cand;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + DB_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_key_switch_device.sv
// KEY/SW input peripheral: address decode, sticky ready/overrun status,
// interrupt enables and the combinational load-data mux.
module io_key_switch_device
    import io_pkg::*;
#(
    parameter int          DBITS           = 32,
    parameter int          KEY_WIDTH       = 4,
    parameter int          SW_WIDTH        = 10,
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic [31:0] ADDR_KDATA      = KDATA_ADDR,
    parameter logic [31:0] ADDR_SDATA      = SDATA_ADDR,
    parameter logic [31:0] ADDR_KCTRL      = KCTRL_ADDR,
    parameter logic [31:0] ADDR_SCTRL      = SCTRL_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBITS-1:0]     addr,
    input  logic [DBITS-1:0]     wrData,
    input  logic                 we,
    input  logic                 re,
    input  logic [KEY_WIDTH-1:0] KEY,
    input  logic [SW_WIDTH-1:0]  SW,
    output logic [DBITS-1:0]     rdData,
    output logic                 hit,
    output logic                 intr
);

    logic [KEY_WIDTH-1:0] keyStable;
    logic [SW_WIDTH-1:0]  swStable;
    logic                 keyChg, swChg;
    logic                 kRdy, kOvr, kIE;
    logic                 sRdy, sOvr, sIE;
    logic                 unusedBits;

    function automatic logic [DBITS-1:0] packCtrl(input logic rdy, input logic ovr, input logic ie);
        logic [DBITS-1:0] v;
        v          = '0;
        v[RDY_BIT] = rdy;
        v[OVR_BIT] = ovr;
        v[IE_BIT]  = ie;
        return v;
    endfunction

    // Buttons are active-low on the board; the debouncer sees 1 = pressed.
    io_debouncer #(
        .WIDTH          (KEY_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) keyDeb (
        .clk   (clk),
        .reset (reset),
        .din   (~KEY),
        .stable(keyStable),
        .change(keyChg)
    );

    io_debouncer #(
        .WIDTH          (SW_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) swDeb (
        .clk   (clk),
        .reset (reset),
        .din   (SW),
        .stable(swStable),
        .change(swChg)
    );

    logic selKData, selSData, selKCtrl, selSCtrl;
    assign selKData = (addr == DBITS'(ADDR_KDATA));
    assign selSData = (addr == DBITS'(ADDR_SDATA));
    assign selKCtrl = (addr == DBITS'(ADDR_KCTRL));
    assign selSCtrl = (addr == DBITS'(ADDR_SCTRL));
    assign hit      = selKData | selSData | selKCtrl | selSCtrl;

    logic kClr, sClr, kStore, sStore;
    assign kClr   = re & selKData;
    assign sClr   = re & selSData;
    assign kStore = we & selKCtrl;
    assign sStore = we & selSCtrl;

    // A new event on the same edge as a clearing read wins: RDY stays set, OVR untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kRdy <= 1'b0;
            kOvr <= 1'b0;
            kIE  <= 1'b0;
            sRdy <= 1'b0;
            sOvr <= 1'b0;
            sIE  <= 1'b0;
        end else begin
            if (keyChg)    kRdy <= 1'b1;
            else if (kClr) kRdy <= 1'b0;
            if (keyChg && kRdy && !kClr)       kOvr <= 1'b1;
            else if (kStore && !wrData[OVR_BIT]) kOvr <= 1'b0;
            if (kStore) kIE <= wrData[IE_BIT];

            if (swChg)     sRdy <= 1'b1;
            else if (sClr) sRdy <= 1'b0;
            if (swChg && sRdy && !sClr)        sOvr <= 1'b1;
            else if (sStore && !wrData[OVR_BIT]) sOvr <= 1'b0;
            if (sStore) sIE <= wrData[IE_BIT];
        end
    end

    assign intr = (kRdy & kIE) | (sRdy & sIE);

    always_comb begin
        rdData = '0;
        if (selKData)      rdData = {{(DBITS-KEY_WIDTH){1'b0}}, keyStable};
        else if (selSData) rdData = {{(DBITS-SW_WIDTH){1'b0}}, swStable};
        else if (selKCtrl) rdData = packCtrl(kRdy, kOvr, kIE);
        else if (selSCtrl) rdData = packCtrl(sRdy, sOvr, sIE);
    end

    assign unusedBits = &{1'b0, wrData[DBITS-1:IE_BIT+1], wrData[IE_BIT-1:OVR_BIT+1], wrData[OVR_BIT-1:0]};

endmodule

// File: tb/tb_io_key_switch_device.sv
// Directed bench for the KEY/SW peripheral with a short debounce window.
`timescale 1ns/1ps
module tb_io_key_switch_device;

    localparam logic [31:0] AKD = 32'hF000_0010;
    localparam logic [31:0] ASD = 32'hF000_0014;
    localparam logic [31:0] AKC = 32'hF000_0110;
    localparam logic [31:0] ASC = 32'hF000_0114;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wrData, rdData;
    logic        we, re, hit, intr;
    logic [3:0]  KEY;
    logic [9:0]  SW;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic        h;
        logic [31:0] d;
    } vec_t;

    vec_t rstTab[4];
    vec_t decTab[6];

    io_key_switch_device #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wrData(wrData),
        .we    (we),
        .re    (re),
        .KEY   (KEY),
        .SW    (SW),
        .rdData(rdData),
        .hit   (hit),
        .intr  (intr)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chkRd(input string nm, input logic [31:0] a, input logic expHit, input logic [31:0] exp);
        addr = a;
        #1;
        total++;
        if (rdData !== exp || hit !== expHit) begin
            bad++;
            $display("FAIL %s: addr=%h rdData=%h hit=%b, required rdData=%h hit=%b",
                     nm, a, rdData, hit, exp, expHit);
        end
    endtask

    task automatic chkIntr(input string nm, input logic exp);
        #1;
        total++;
        if (intr !== exp) begin
            bad++;
            $display("FAIL %s: intr=%b, required %b", nm, intr, exp);
        end
    endtask

    task automatic load(input logic [31:0] a);
        addr = a;
        re   = 1'b1;
        tick(1);
        re   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wrData = d;
        we     = 1'b1;
        tick(1);
        we     = 1'b0;
    endtask

    initial begin
        rstTab[0] = '{AKD, 1'b1, 32'h0};
        rstTab[1] = '{ASD, 1'b1, 32'h0};
        rstTab[2] = '{AKC, 1'b1, 32'h0};
        rstTab[3] = '{ASC, 1'b1, 32'h0};

        decTab[0] = '{32'hF000_0018, 1'b0, 32'h0};
        decTab[1] = '{32'h0000_0010, 1'b0, 32'h0};
        decTab[2] = '{AKD, 1'b1, 32'h3};
        decTab[3] = '{ASD, 1'b1, 32'h1};
        decTab[4] = '{AKC, 1'b1, 32'h0};
        decTab[5] = '{ASC, 1'b1, 32'h100};

        reset  = 1'b1;
        KEY    = 4'hF;
        SW     = '0;
        addr   = '0;
        wrData = '0;
        we     = 1'b0;
        re     = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(3);

        // Reset mid-run with a pending RDY, IE set and SW mid-debounce.
        KEY = 4'hE;
        tick(8);
        chkRd("pre_rst_kctrl", AKC, 1'b1, 32'h1);
        store(ASC, 32'h100);
        SW = 10'h3;
        tick(4);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++)
            chkRd("rst_tab", rstTab[i].a, rstTab[i].h, rstTab[i].d);
        chkIntr("rst_intr", 1'b0);
        KEY = 4'hF;
        SW  = '0;
        tick(2);
        reset = 1'b0;
        tick(10);
        chkRd("post_rst_kctrl", AKC, 1'b1, 32'h0);
        chkRd("post_rst_sctrl", ASC, 1'b1, 32'h0);

        // Debounce latency: stable and RDY appear exactly at the 7th edge.
        KEY = 4'hE;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            chkRd("lat_kdata", AKD, 1'b1, (e == 7) ? 32'h1 : 32'h0);
            chkRd("lat_kctrl", AKC, 1'b1, (e == 7) ? 32'h1 : 32'h0);
        end

        // Glitch shorter than the window is rejected.
        SW = 10'h020;
        tick(3);
        SW = '0;
        tick(10);
        chkRd("glitch_sdata", ASD, 1'b1, 32'h0);
        chkRd("glitch_sctrl", ASC, 1'b1, 32'h0);

        // Release without reading -> overrun; store clears OVR; load clears RDY.
        KEY = 4'hF;
        tick(7);
        chkRd("ovr_kdata", AKD, 1'b1, 32'h0);
        chkRd("ovr_kctrl", AKC, 1'b1, 32'h5);
        store(AKC, 32'h0);
        chkRd("ovr_clr", AKC, 1'b1, 32'h1);
        load(AKD);
        chkRd("rdy_clr", AKC, 1'b1, 32'h0);
        store(AKC, 32'h105);
        chkRd("ctrl_ro_bits", AKC, 1'b1, 32'h100);
        store(AKC, 32'h0);
        chkRd("ctrl_ie_off", AKC, 1'b1, 32'h0);

        // Collision: clearing read on the change edge while RDY is already set.
        KEY = 4'hD;
        tick(7);
        chkRd("col_pre", AKC, 1'b1, 32'h1);
        KEY = 4'hC;
        tick(6);
        load(AKD);
        chkRd("col_kctrl", AKC, 1'b1, 32'h1);
        chkRd("col_kdata", AKD, 1'b1, 32'h3);
        load(AKD);
        chkRd("col_clear", AKC, 1'b1, 32'h0);

        // Interrupt follows SW RDY with IE set.
        store(ASC, 32'h100);
        chkRd("ie_set", ASC, 1'b1, 32'h100);
        SW = 10'h001;
        tick(6);
        chkIntr("intr_before", 1'b0);
        tick(1);
        chkIntr("intr_rise", 1'b1);
        chkRd("intr_sdata", ASD, 1'b1, 32'h1);
        chkRd("intr_sctrl", ASC, 1'b1, 32'h101);
        load(ASD);
        chkIntr("intr_fall", 1'b0);

        // Decode: unmapped accesses and stores to data regs change nothing.
        load(32'hF000_0018);
        store(AKD, 32'hFFFF_FFFF);
        store(32'hF000_0018, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++)
            chkRd("dec_tab", decTab[i].a, decTab[i].h, decTab[i].d);
        chkIntr("dec_intr", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
